calculator_arbiter: RTL and testbench
=====================================

Name: calculator_arbiter

Overview:
- Shares one instance of the team's combinational `calculator` (4-bit specialized multiplier) between two requesters.
- Each operation is arbitrated round-robin, the winner's operand is registered, and the result is returned with the requester ID and an error flag.
- A wrapping count of completed operations is kept.
- Sits between the two operand sources and the single `calculator` datapath.

Parameters:
- FIRST_GRANT, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request; held until ack0 is seen.
- in0  input  4  requester 0 operand; stable while req0 is high.
- req1  input  1  requester 1 request.
- in1  input  4  requester 1 operand.
- ack0  output  1  one-cycle pulse: requester 0's operand was captured.
- ack1  output  1  one-cycle pulse: requester 1's operand was captured.
- out  output  4  registered calculator result.
- out_valid  output  1  one-cycle pulse: out, out_id and out_err are valid.
- out_id  output  1  requester that owns the current result.
- out_err  output  1  operand was out of range (9..15).
- busy  output  1  high in CALC and DONE.
- done_cnt  output  8  count of completed operations.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 immediately clears: state=IDLE, ack0=ack1=0, out=0, out_valid=0, out_id=0, out_err=0, busy=0, done_cnt=0, op_reg=0.
  - last_grant is set to ~FIRST_GRANT.
  - Any in-flight operation is dropped and produces no out_valid.
- Calculator function (existing module, 4-bit in/out, instantiated unchanged, input driven from op_reg):
  - x = 0,1,2 -> x.
  - x = 3,4,5 -> 2x+1 (7, 9, 11).
  - x = 6,7,8 -> 2x-1 (11, 13, 15).
  - x = 9..15 -> 0.
  - No overflow is possible.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On a clock edge with req0|req1=1:
    - Pick the winner.
    - op_reg <= winner's operand; id_reg <= winner; last_grant <= winner.
    - Assert that requester's ack during the next cycle (registered).
    - Go to CALC.
  - With no request, stay in IDLE.
- Arbitration:
  - Only one requesting -> that one wins.
  - Both requesting -> the one that is not last_grant wins (strict alternation under sustained contention).
- CALC:
  - ack(id_reg)=1 for exactly this cycle.
  - At the edge: out <= calculator(op_reg); out_err <= (op_reg > 8); out_id <= id_reg; go to DONE.
- DONE:
  - out_valid=1 for this cycle.
  - At the edge: done_cnt <= done_cnt+1 (wraps 255 -> 0); go to IDLE.
- Latency and throughput:
  - Sampling edge -> ack in the following cycle -> out_valid one cycle later.
  - One operation per 3 cycles maximum.
- Output holding:
  - out, out_id and out_err hold their values after DONE until the next CALC->DONE edge.
  - out_valid is 0 outside DONE.
- Handshake rules:
  - Requests are sampled only in IDLE; req during CALC/DONE is ignored, not queued.
  - A requester still asserting req when the FSM returns to IDLE is treated as a new request.
  - Requesters must drop req (or change the operand for a new op) on the cycle after seeing ack.
- Out-of-range operand: out=0, out_err=1. It counts toward done_cnt and still advances last_grant.
- Simultaneous request arriving at the same edge as the DONE->IDLE transition: not sampled; it is sampled at the next edge.

Test Plan:
- Reset with rst_n=0 mid-CALC -> all outputs 0 asynchronously, no out_valid afterwards, done_cnt=0.
- req0=1, in0=4 alone -> ack0 pulses one cycle later; next cycle out_valid=1, out=9, out_id=0, out_err=0, done_cnt=1.
- Operand sweep 0..15 via req1 -> outputs are 0,1,2,7,9,11,11,13,15,0,0,0,0,0,0,0; out_err=1 for 9..15.
- Both requesters held, in0=3, in1=8, FIRST_GRANT=0:
  - Grants alternate 0,1,0,1.
  - Results alternate 7 (id 0) and 15 (id 1), one out_valid every 3 cycles.
- req1 asserted during CALC and dropped before IDLE -> no ack1, no extra result.
- 256 back-to-back operations -> done_cnt wraps to 0 at the 256th out_valid.

Source files
------------

// File: rtl/calculator_arbiter_if.sv
// Purpose: bundles the two-requester operand/ack handshake and the result bus
//          of calculator_arbiter into one interface.
// Ports: req0/in0/req1/in1 come from the requesters; ack0/ack1 and the result
//        group (out, out_valid, out_id, out_err, busy, done_cnt) go back to them.
interface calculator_arbiter_if;
  logic       req0;
  logic [3:0] in0;
  logic       req1;
  logic [3:0] in1;
  logic       ack0;
  logic       ack1;
  logic [3:0] out;
  logic       out_valid;
  logic       out_id;
  logic       out_err;
  logic       busy;
  logic [7:0] done_cnt;

  // Requester side: drives requests and operands, observes acks and results.
  modport master (
    output req0, in0, req1, in1,
    input  ack0, ack1, out, out_valid, out_id, out_err, busy, done_cnt
  );

  // Arbiter side.
  modport slave (
    input  req0, in0, req1, in1,
    output ack0, ack1, out, out_valid, out_id, out_err, busy, done_cnt
  );
endinterface

// File: rtl/calculator_arbiter.sv
// Purpose: round-robin sharing of one combinational calculator between two
//          requesters; result returned with owner id and out-of-range flag.
// Latency: sampling edge -> ack next cycle -> out_valid the cycle after; one op per 3 cycles.
// Backpressure: none on the result; requests are only sampled in IDLE, anything
//               asserted during CALC/DONE is ignored rather than queued.
// Ports: clk, rst_n (async active-low), bus (calculator_arbiter_if.slave).

// Existing 4-bit specialised multiplier, purely combinational.
module calculator (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    y = 4'd0;
    case (x)
      4'd0, 4'd1, 4'd2: y = x;
      4'd3, 4'd4, 4'd5: y = {x[2:0], 1'b1};          // 2x+1
      4'd6, 4'd7, 4'd8: y = {x[2:0], 1'b0} - 4'd1;   // 2x-1 (8 wraps 0-1 -> 15)
      default:          y = 4'd0;
    endcase
  end
endmodule

module calculator_arbiter #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  calculator_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] op_reg;
  logic       id_reg;
  logic       last_grant;
  logic       winner;
  logic [3:0] calc_y;

  calculator u_calc (
    .x (op_reg),
    .y (calc_y)
  );

  // Sole requester wins; under contention the one not granted last time wins,
  // giving strict alternation while both keep requesting.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) winner = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_reg        <= 4'd0;
      id_reg        <= 1'b0;
      last_grant    <= ~FIRST_GRANT;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.out       <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.out_id    <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done_cnt  <= 8'd0;
    end else begin
      // Pulses default low; each state raises its own for one cycle.
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            op_reg     <= winner ? bus.in1 : bus.in0;
            id_reg     <= winner;
            last_grant <= winner;
            bus.ack0   <= ~winner;
            bus.ack1   <= winner;
            bus.busy   <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          bus.out       <= calc_y;
          bus.out_err   <= (op_reg > 4'd8);
          bus.out_id    <= id_reg;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.done_cnt <= bus.done_cnt + 8'd1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calculator_arbiter.sv
// Directed bench for calculator_arbiter: reset, single op, operand sweep,
// async reset mid-operation, contention alternation, ignored late request,
// and done_cnt wrap after 256 operations.
module tb_calculator_arbiter;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   exp_cnt;
  int   pulses;

  calculator_arbiter_if bus ();

  calculator_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation from requester id with operand x; y is the hand-computed result.
  task automatic single_op(input logic id, input logic [3:0] x, input logic [3:0] y);
    if (id) begin bus.req1 = 1'b1; bus.in1 = x; end
    else    begin bus.req0 = 1'b1; bus.in0 = x; end
    tick();
    chk("ack0", {31'd0, bus.ack0}, {31'd0, ~id});
    chk("ack1", {31'd0, bus.ack1}, {31'd0, id});
    chk("busy_calc", {31'd0, bus.busy}, 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("out", {28'd0, bus.out}, {28'd0, y});
    chk("out_id", {31'd0, bus.out_id}, {31'd0, id});
    chk("out_err", {31'd0, bus.out_err}, {31'd0, (x > 4'd8)});
    tick();
    exp_cnt++;
    chk("out_valid_low", {31'd0, bus.out_valid}, 32'd0);
    chk("done_cnt", {24'd0, bus.done_cnt}, exp_cnt[31:0] & 32'hff);
  endtask

  logic [3:0] sweep_exp [16] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd9, 4'd11, 4'd11, 4'd13,
                                 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_cnt    = 0;
    pulses     = 0;
    bus.req0 = 1'b0; bus.in0 = 4'd0;
    bus.req1 = 1'b0; bus.in1 = 4'd0;
    rst_n = 1'b0;

    // Reset state (before any clock edge).
    #1;
    chk("rst_out", {28'd0, bus.out}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_done_cnt", {24'd0, bus.done_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Single op: 4 -> 9.
    single_op(1'b0, 4'd4, 4'd9);

    // Operand sweep through requester 1.
    for (int i = 0; i < 16; i++) single_op(1'b1, i[3:0], sweep_exp[i]);

    // Async reset while an op is in CALC: out_id/out_err were 1 from x=15.
    bus.req1 = 1'b1; bus.in1 = 4'd5;
    tick();
    chk("midcalc_ack1", {31'd0, bus.ack1}, 32'd1);
    bus.req1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack1", {31'd0, bus.ack1}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_out_id", {31'd0, bus.out_id}, 32'd0);
    chk("arst_out_err", {31'd0, bus.out_err}, 32'd0);
    chk("arst_done_cnt", {24'd0, bus.done_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    exp_cnt = 0;

    // Contention: both held, in0=3 (->7), in1=8 (->15); grants 0,1,0,1.
    bus.req0 = 1'b1; bus.in0 = 4'd3;
    bus.req1 = 1'b1; bus.in1 = 4'd8;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_ack0", {31'd0, bus.ack0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ack1", {31'd0, bus.ack1}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("cont_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("cont_out", {28'd0, bus.out}, (k % 2 == 0) ? 32'd7 : 32'd15);
      chk("cont_id", {31'd0, bus.out_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      exp_cnt++;
      chk("cont_gap", {31'd0, bus.out_valid}, 32'd0);
      chk("cont_cnt", {24'd0, bus.done_cnt}, exp_cnt[31:0]);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // req1 raised during CALC and dropped before IDLE is not served.
    bus.req0 = 1'b1; bus.in0 = 4'd2;
    tick();
    chk("late_ack0", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.in1 = 4'd5;
    tick();
    chk("late_out", {28'd0, bus.out}, 32'd2);
    chk("late_ack1_a", {31'd0, bus.ack1}, 32'd0);
    bus.req1 = 1'b0;
    tick();
    exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_ack1", {31'd0, bus.ack1}, 32'd0);
      chk("late_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    chk("late_cnt", {24'd0, bus.done_cnt}, exp_cnt[31:0]);

    // 256 back-to-back ops with req0 held: done_cnt wraps to 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.in0 = 4'd1;
    for (int i = 0; i < 256; i++) begin
      tick();
      tick();
      if (bus.out_valid === 1'b1) pulses++;
      tick();
      if (i == 254) chk("wrap_255", {24'd0, bus.done_cnt}, 32'd255);
    end
    bus.req0 = 1'b0;
    chk("wrap_0", {24'd0, bus.done_cnt}, 32'd0);
    chk("wrap_pulses", pulses, 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
